// File: rtl/wrr_rank_requester.sv
// Initiator side of the WRR rank handshake: queues classified descriptors, looks up the
// class weight, asks the calc engine for a rank, and forwards the ranked descriptor.
module wrr_rank_requester #(
    parameter int CLASS_WIDTH     = 5,
    parameter int WEIGHT_WIDTH    = 16,
    parameter int RESULT_WIDTH    = 32,
    parameter int META_WIDTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int TIMEOUT_CYCLES  = 15
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CLASS_WIDTH-1:0]  in_class_id,
    input  logic [META_WIDTH-1:0]   in_meta,
    input  logic                    cfg_wr_en,
    input  logic [CLASS_WIDTH-1:0]  cfg_class_id,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
    output logic                    req_valid,
    output logic [CLASS_WIDTH-1:0]  req_class_id,
    output logic [WEIGHT_WIDTH-1:0] req_class_weight,
    input  logic                    resp_valid,
    input  logic [RESULT_WIDTH-1:0] resp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RESULT_WIDTH-1:0] out_rank,
    output logic [CLASS_WIDTH-1:0]  out_class_id,
    output logic [META_WIDTH-1:0]   out_meta,
    output logic                    err_timeout,
    output logic                    busy
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
    // high; valid never waits on ready, and payload is held stable while valid && !ready.
    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam int TAB_DEPTH = 1 << CLASS_WIDTH;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENTRY_W   = CLASS_WIDTH + META_WIDTH;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT   = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]         TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WEIGHT_WIDTH-1:0]  WEIGHT_ONE = WEIGHT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                     state;
    logic [ENTRY_W-1:0]         fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   fifo_cnt;
    logic [FIFO_DEPTH_LOG2:0]   cnt_nxt;
    logic [WEIGHT_WIDTH-1:0]    wtab [TAB_DEPTH];
    logic [CLASS_WIDTH-1:0]     hold_class;
    logic [META_WIDTH-1:0]      hold_meta;
    logic [WEIGHT_WIDTH-1:0]    hold_weight;
    logic [CNT_W-1:0]           tmo_cnt;
    logic [ENTRY_W-1:0]         head;
    logic [CLASS_WIDTH-1:0]     head_class;
    logic [META_WIDTH-1:0]      head_meta;
    logic                       push;
    logic                       pop;

    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (fifo_cnt != '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_class = head[ENTRY_W-1:META_WIDTH];
    assign head_meta  = head[META_WIDTH-1:0];

    // The engine samples the request fields during its calc cycle, so they are driven
    // straight from the holding registers and only change on the next pop.
    assign req_class_id     = hold_class;
    assign req_class_weight = hold_weight;
    assign out_class_id     = hold_class;
    assign out_meta         = hold_meta;

    always_comb begin
        cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            cnt_nxt = fifo_cnt + 1'b1;
        end else if (!push && pop) begin
            cnt_nxt = fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_class_id, in_meta};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            in_ready    <= 1'b0;
            hold_class  <= '0;
            hold_meta   <= '0;
            hold_weight <= '0;
            tmo_cnt     <= '0;
            req_valid   <= 1'b0;
            out_valid   <= 1'b0;
            out_rank    <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < TAB_DEPTH; i++) begin
                wtab[i] <= WEIGHT_ONE;
            end
        end else begin
            fifo_cnt    <= cnt_nxt;
            in_ready    <= (cnt_nxt != FULL_CNT);
            req_valid   <= 1'b0;
            err_timeout <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // The engine computes weight-1, so a zero weight is clamped to one.
            if (cfg_wr_en) begin
                wtab[cfg_class_id] <= (cfg_weight == '0) ? WEIGHT_ONE : cfg_weight;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rd_ptr      <= rd_ptr + 1'b1;
                        hold_class  <= head_class;
                        hold_meta   <= head_meta;
                        hold_weight <= wtab[head_class];
                        req_valid   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        out_rank  <= resp_data;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt     <= tmo_cnt + 1'b1;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wrr_rank_requester.sv
// Bench for wrr_rank_requester: engine responder, transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_wrr_rank_requester;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_class_id;
    logic [31:0] in_meta;
    logic        cfg_wr_en;
    logic [4:0]  cfg_class_id;
    logic [15:0] cfg_weight;
    logic        req_valid;
    logic [4:0]  req_class_id;
    logic [15:0] req_class_weight;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rank;
    logic [4:0]  out_class_id;
    logic [31:0] out_meta;
    logic        err_timeout;
    logic        busy;

    wrr_rank_requester dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_class_id(in_class_id), .in_meta(in_meta),
        .cfg_wr_en(cfg_wr_en), .cfg_class_id(cfg_class_id), .cfg_weight(cfg_weight),
        .req_valid(req_valid), .req_class_id(req_class_id), .req_class_weight(req_class_weight),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rank(out_rank),
        .out_class_id(out_class_id), .out_meta(out_meta),
        .err_timeout(err_timeout), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    logic up;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) up <= 1'b0;
        else       up <= 1'b1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- engine responder ----------------
    int          eng_mute  = 0;
    int          stray_req = 0;
    int          eng_cd    = 0;
    logic [31:0] rank_next = 32'h8000_1000;
    logic [31:0] rank_q[$];

    initial begin
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (!rstn) begin
                eng_cd = 0;
                rank_q.delete();
            end else begin
                if (stray_req != 0) begin
                    resp_valid = 1'b1;
                    resp_data  = 32'hDEAD_BEEF;
                    stray_req  = 0;
                end
                if (eng_cd != 0) begin
                    eng_cd--;
                    if (eng_cd == 0) begin
                        resp_valid = 1'b1;
                        resp_data  = rank_next;
                        rank_q.push_back(rank_next);
                        rank_next  = rank_next + 32'h10;
                    end
                end
                if (req_valid && eng_mute == 0) eng_cd = 2;
            end
        end
    end

    // ---------------- reference model + compare ----------------
    typedef struct {
        logic [4:0]  cls;
        logic [31:0] meta;
    } desc_t;

    desc_t       exp_q[$];
    desc_t       cur;
    logic [15:0] wt_m [32];
    int          occ, since;
    bit          have_cur, cur_drop, post_hs;
    bit          prev_hs, prev_req, prev_ov, prev_ordy;
    bit          pend_en;
    logic [4:0]  pend_cls;
    logic [15:0] pend_w;
    logic [31:0] sv_rank, sv_meta, rk;
    logic [4:0]  sv_cls;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                for (int i = 0; i < 32; i++) wt_m[i] = 16'd1;
                occ = 0; since = 0; have_cur = 0; cur_drop = 0; post_hs = 0;
                prev_hs = 0; prev_req = 0; prev_ov = 0; prev_ordy = 0; pend_en = 0;
                continue;
            end
            if (post_hs) chk("out_valid_drop", out_valid, 0);
            post_hs = 0;
            if (have_cur) since++;
            if (prev_hs) occ++;
            if (req_valid) begin
                occ--;
                chk("req_single_pulse", prev_req, 0);
                chk("req_one_outstanding", have_cur, 0);
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("req_class", req_class_id, cur.cls);
                    chk("req_weight", req_class_weight, wt_m[cur.cls]);
                end
                have_cur = 1; cur_drop = (eng_mute != 0); since = 0;
            end
            chk("in_ready", in_ready, (up && occ < 4));
            if (prev_ov && !prev_ordy) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_out_rank", out_rank, sv_rank);
                chk("stall_out_class", out_class_id, sv_cls);
                chk("stall_out_meta", out_meta, sv_meta);
            end
            if (out_valid && !prev_ov) begin
                chk("out_expected", have_cur && !cur_drop, 1);
                chk("out_latency", since, 3);
            end
            if (have_cur && !cur_drop && since == 3) chk("out_present", out_valid, 1);
            if (out_valid && out_ready) begin
                chk("out_class", out_class_id, cur.cls);
                chk("out_meta", out_meta, cur.meta);
                chk("out_rank_avail", rank_q.size() != 0, 1);
                if (rank_q.size() != 0) begin
                    rk = rank_q.pop_front();
                    chk("out_rank", out_rank, rk);
                end
                have_cur = 0; post_hs = 1;
            end
            if (err_timeout) begin
                chk("timeout_expected", have_cur && cur_drop, 1);
                chk("timeout_delay", since, 16);
                chk("timeout_idle", busy, 0);
                have_cur = 0;
            end else if (have_cur && cur_drop && since > 16) begin
                chk("timeout_missing", err_timeout, 1);
                have_cur = 0;
            end
            if (have_cur) chk("busy", busy, 1);
            // a write in this cycle lands after the pop that may share its edge
            if (pend_en) wt_m[pend_cls] = (pend_w == 16'd0) ? 16'd1 : pend_w;
            pend_en = cfg_wr_en; pend_cls = cfg_class_id; pend_w = cfg_weight;
            if (in_valid && in_ready) exp_q.push_back('{cls: in_class_id, meta: in_meta});
            prev_hs = in_valid && in_ready;
            prev_req = req_valid; prev_ov = out_valid; prev_ordy = out_ready;
            sv_rank = out_rank; sv_cls = out_class_id; sv_meta = out_meta;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] c, input logic [15:0] w);
        cfg_wr_en = 1'b1; cfg_class_id = c; cfg_weight = w;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic push_desc(input logic [4:0] c, input logic [31:0] m);
        int n = 0;
        in_valid = 1'b1; in_class_id = c; in_meta = m;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_for(input int which, input string name, input int limit, output int n);
        bit hit;
        n = 0;
        forever begin
            case (which)
                0:       hit = req_valid;
                1:       hit = out_valid;
                2:       hit = err_timeout;
                default: hit = !busy && !out_valid && exp_q.size() == 0 && !have_cur;
            endcase
            if (hit || n >= limit) break;
            tick();
            n++;
        end
        chk(name, hit, 1);
    endtask

    // ---------------- directed scenarios ----------------
    int n, cnt;

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_class_id = '0; in_meta = '0;
        cfg_wr_en = 1'b0; cfg_class_id = '0; cfg_weight = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_fields", {req_class_id, req_class_weight}, 0);
        chk("rst_out", {out_valid, out_rank, out_class_id, out_meta}, 0);
        chk("rst_err_busy", {err_timeout, busy}, 0);
        rstn = 1'b1;

        // single descriptor, latency and payload
        cfg_write(5'd3, 16'd4);
        push_desc(5'd3, 32'hAA);
        chk("t1_no_req_yet", req_valid, 0);
        tick();
        chk("t1_req_valid", req_valid, 1);
        chk("t1_req_class", req_class_id, 3);
        chk("t1_req_weight", req_class_weight, 4);
        tick();
        chk("t1_req_pulse_end", req_valid, 0);
        tick();
        tick();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_rank", out_rank, 32'h8000_1000);
        chk("t1_out_meta", out_meta, 32'hAA);
        chk("t1_out_class", out_class_id, 3);
        tick();
        chk("t1_out_drop", out_valid, 0);
        wait_for(3, "t1_idle", 200, n);

        // stalled output with stray response, FIFO filling behind it
        out_ready = 1'b0;
        push_desc(5'd2, 32'h22);
        wait_for(1, "t2_out_wait", 50, n);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    push_desc(5'(10 + i), 32'h100 + i);
                    if (i == 3) chk("t2_fifo_full", in_ready, 0);
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    chk("t2_stall_valid", out_valid, 1);
                    chk("t2_stall_rank", out_rank, 32'h8000_1010);
                    chk("t2_stall_meta", out_meta, 32'h22);
                    if (k == 3) stray_req = 1;
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_for(3, "t2_idle", 300, n);

        // zero weight clamps to one
        cfg_write(5'd7, 16'd0);
        push_desc(5'd7, 32'h77);
        wait_for(0, "t3_req_wait", 50, n);
        chk("t3_weight_clamp", req_class_weight, 1);
        wait_for(3, "t3_idle", 200, n);

        // engine silence -> single timeout pulse, then normal service
        eng_mute = 1;
        push_desc(5'd9, 32'h99);
        wait_for(0, "t4_req_wait", 50, n);
        wait_for(2, "t4_timeout_wait", 40, n);
        chk("t4_timeout_cycles", n, 16);
        chk("t4_busy_low", busy, 0);
        eng_mute = 0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (err_timeout) cnt++;
        end
        chk("t4_single_pulse", cnt, 0);
        push_desc(5'd4, 32'h44);
        wait_for(3, "t4_idle", 200, n);

        // asynchronous reset during WAIT with two descriptors queued
        eng_mute = 1;
        push_desc(5'd5, 32'h55);
        wait_for(0, "t6_req_wait", 50, n);
        push_desc(5'd6, 32'h66);
        push_desc(5'd8, 32'h88);
        tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_req", {req_valid, req_class_id, req_class_weight}, 0);
        chk("t6_rst_out", {out_valid, out_rank, out_class_id, out_meta}, 0);
        chk("t6_rst_err_busy", {err_timeout, busy}, 0);
        tick();
        tick();
        rstn = 1'b1;
        eng_mute = 0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (req_valid || out_valid) cnt++;
        end
        chk("t6_quiet_after_rst", cnt, 0);
        chk("t6_in_ready", in_ready, 1);
        push_desc(5'd3, 32'h33);
        wait_for(0, "t6_req_wait2", 50, n);
        chk("t6_weight_reset", req_class_weight, 1);
        wait_for(3, "t6_idle", 200, n);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
